// File: rtl/minimig_autoconfig_ctrl.sv
// AutoConfig bus responder: walks the board chain (Z2 RAM, Z3 RAM, Ethernet), serves
// nybble reads from the AutoConfig ROM and latches the base addresses the OS assigns.
module minimig_autoconfig_ctrl #(
    parameter int Z2_BOARD  = 0,
    parameter int Z3_BOARD  = 1,
    parameter int ETH_BOARD = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_sel,
    input  logic        req,
    input  logic        rw,
    input  logic [8:1]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    input  logic        en_z3ram,
    input  logic        en_eth,
    input  logic [1:0]  z2ram_size,
    output logic [7:0]  rom_a_read,
    input  logic [3:0]  rom_q,
    output logic [7:0]  rom_a_write,
    output logic [3:0]  rom_d,
    output logic        rom_we,
    output logic [7:0]  z2ram_base,
    output logic        z2ram_cfg,
    output logic [15:0] z3ram_base,
    output logic        z3ram_cfg,
    output logic [15:0] eth_base,
    output logic        eth_cfg,
    output logic        done
);

    localparam logic [1:0] Z2_IDX  = Z2_BOARD[1:0];
    localparam logic [1:0] Z3_IDX  = Z3_BOARD[1:0];
    localparam logic [1:0] ETH_IDX = ETH_BOARD[1:0];

    typedef enum logic [2:0] {
        S_INIT,
        S_FIRST,
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [1:0]  board_q;
    logic [3:0]  nib_q;
    logic        ack_q;
    logic [15:0] rdata_q;
    logic        rom_we_q;
    logic [3:0]  rom_d_q;
    logic [7:0]  z2_base_q;
    logic        z2_cfg_q;
    logic [15:0] z3_base_q;
    logic        z3_cfg_q;
    logic [15:0] eth_base_q;
    logic        eth_cfg_q;
    logic        done_q;
    logic [7:0]  wr_off_q;
    logic [15:0] wdata_q;

    logic [3:0]  en_mask;
    logic [2:0]  first_d;
    logic [2:0]  next_d;
    logic        ld_nib, ld_z2, ld_z3, ld_eth, adv;
    logic        unused_ok;

    // Lowest enabled board index at or above start; bit 2 set means none left.
    function automatic logic [2:0] find_board(input logic [2:0] start, input logic [3:0] mask);
        logic [2:0] res;
        res = 3'b100;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(start) && mask[i]) res = 3'(i);
        end
        return res;
    endfunction

    function automatic logic [3:0] size_nybble(input logic [1:0] size);
        case (size)
            2'b01:   return 4'b0110;
            2'b10:   return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    always_comb begin
        en_mask = 4'b0000;
        en_mask[Z2_IDX]  = (z2ram_size != 2'b00);
        en_mask[Z3_IDX]  = en_z3ram;
        en_mask[ETH_IDX] = en_eth;
    end

    assign first_d = find_board(3'd0, en_mask);
    assign next_d  = find_board({1'b0, board_q} + 3'd1, en_mask);

    // Write decode: a base write only lands on the board that owns that register.
    always_comb begin
        ld_nib = 1'b0;
        ld_z2  = 1'b0;
        ld_z3  = 1'b0;
        ld_eth = 1'b0;
        adv    = 1'b0;
        case (wr_off_q)
            8'h4A: ld_nib = (board_q == Z2_IDX);
            8'h48: ld_z2  = (board_q == Z2_IDX);
            8'h44: begin
                ld_z3  = (board_q == Z3_IDX);
                ld_eth = (board_q == ETH_IDX);
            end
            8'h4C: adv = 1'b1;
            default: ;
        endcase
        adv = adv | ld_z2 | ld_z3 | ld_eth;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_INIT;
            board_q    <= 2'd0;
            nib_q      <= 4'hF;
            ack_q      <= 1'b0;
            rdata_q    <= 16'hFFFF;
            rom_we_q   <= 1'b0;
            rom_d_q    <= 4'h0;
            z2_base_q  <= 8'h00;
            z2_cfg_q   <= 1'b0;
            z3_base_q  <= 16'h0000;
            z3_cfg_q   <= 1'b0;
            eth_base_q <= 16'h0000;
            eth_cfg_q  <= 1'b0;
            done_q     <= 1'b0;
            wr_off_q   <= 8'h00;
            wdata_q    <= 16'h0000;
        end else begin
            ack_q    <= 1'b0;
            rom_we_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    rom_we_q <= (z2ram_size != 2'b00);
                    rom_d_q  <= size_nybble(z2ram_size);
                    state_q  <= S_FIRST;
                end
                S_FIRST: begin
                    if (first_d[2]) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        board_q <= first_d[1:0];
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (req && cfg_sel) begin
                        wr_off_q <= {addr[7:1], 1'b0};
                        wdata_q  <= wdata;
                        state_q  <= rw ? S_RD : S_WR;
                    end
                end
                S_RD: begin
                    rdata_q <= {rom_q, 12'hFFF};
                    ack_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_WR: begin
                    ack_q   <= 1'b1;
                    state_q <= S_IDLE;
                    if (ld_nib) nib_q <= wdata_q[15:12];
                    if (ld_z2) begin
                        z2_base_q <= {wdata_q[15:12], nib_q};
                        z2_cfg_q  <= 1'b1;
                    end
                    if (ld_z3) begin
                        z3_base_q <= wdata_q;
                        z3_cfg_q  <= 1'b1;
                    end
                    if (ld_eth) begin
                        eth_base_q <= wdata_q;
                        eth_cfg_q  <= 1'b1;
                    end
                    if (adv) begin
                        if (next_d[2]) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            board_q <= next_d[1:0];
                        end
                    end
                end
                S_DONE: begin
                    if (req && cfg_sel) begin
                        ack_q   <= 1'b1;
                        rdata_q <= 16'hFFFF;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    // ROM read port is addressed combinationally so its data lands in RD.
    assign rom_a_read  = {board_q, addr[6:1]};
    assign rom_a_write = {Z2_IDX, 6'h01};
    assign rom_d       = rom_d_q;
    assign rom_we      = rom_we_q;
    assign rdata       = rdata_q;
    assign ack         = ack_q;
    assign z2ram_base  = z2_base_q;
    assign z2ram_cfg   = z2_cfg_q;
    assign z3ram_base  = z3_base_q;
    assign z3ram_cfg   = z3_cfg_q;
    assign eth_base    = eth_base_q;
    assign eth_cfg     = eth_cfg_q;
    assign done        = done_q;
    assign unused_ok   = addr[8];

endmodule

// File: tb/tb_minimig_autoconfig_ctrl.sv
// Directed bench for minimig_autoconfig_ctrl with a behavioural 256x4 AutoConfig ROM.
module tb_minimig_autoconfig_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_sel = 1'b0;
    logic        req = 1'b0;
    logic        rw = 1'b1;
    logic [8:1]  addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        ack;
    logic        en_z3ram = 1'b1;
    logic        en_eth = 1'b1;
    logic [1:0]  z2ram_size = 2'b11;
    logic [7:0]  rom_a_read;
    logic [3:0]  rom_q = 4'hF;
    logic [7:0]  rom_a_write;
    logic [3:0]  rom_d;
    logic        rom_we;
    logic [7:0]  z2ram_base;
    logic        z2ram_cfg;
    logic [15:0] z3ram_base;
    logic        z3ram_cfg;
    logic [15:0] eth_base;
    logic        eth_cfg;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    logic [7:0] we_addr = '0;
    logic [3:0] we_d = '0;
    logic [3:0] rom [256];

    minimig_autoconfig_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cfg_sel(cfg_sel), .req(req), .rw(rw),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack),
        .en_z3ram(en_z3ram), .en_eth(en_eth), .z2ram_size(z2ram_size),
        .rom_a_read(rom_a_read), .rom_q(rom_q), .rom_a_write(rom_a_write),
        .rom_d(rom_d), .rom_we(rom_we),
        .z2ram_base(z2ram_base), .z2ram_cfg(z2ram_cfg),
        .z3ram_base(z3ram_base), .z3ram_cfg(z3ram_cfg),
        .eth_base(eth_base), .eth_cfg(eth_cfg), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_we) rom[rom_a_write] <= rom_d;
        rom_q <= rom[rom_a_read];
    end

    always @(negedge clk) begin
        if (reset_n && rom_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = rom_a_write;
            we_d    = rom_d;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_access(input string tag, input logic is_rd, input logic [8:0] off,
                              input logic [15:0] wd, input int exp_lat);
        int lat;
        bit seen;
        @(negedge clk);
        cfg_sel = 1'b1;
        req     = 1'b1;
        rw      = is_rd;
        addr    = off[8:1];
        wdata   = wd;
        @(negedge clk);
        req  = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            if (ack) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check_eq({tag, " ack latency"}, lat, exp_lat);
        cfg_sel = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [8:0] off, input logic [15:0] exp,
                           input int exp_lat);
        bus_access(tag, 1'b1, off, 16'h0000, exp_lat);
        check_eq({tag, " rdata"}, rdata, exp);
    endtask

    task automatic do_write(input string tag, input logic [8:0] off, input logic [15:0] wd,
                            input int exp_lat);
        bus_access(tag, 1'b0, off, wd, exp_lat);
    endtask

    task automatic release_reset();
        we_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 4'hF;
        rom[8'h00] = 4'hE;
        rom[8'h01] = 4'h5;
        rom[8'h08] = 4'hE;
        rom[8'h09] = 4'hC;
        rom[8'h0A] = 4'h6;
        rom[8'h0B] = 4'h3;
        rom[8'h20] = 4'h5;
        rom[8'h40] = 4'hA;
        rom[8'h80] = 4'h8;

        // Reset values with all three boards present
        repeat (2) @(negedge clk);
        check_eq("rst ack", ack, 1'b0);
        check_eq("rst rdata", rdata, 16'hFFFF);
        check_eq("rst rom_we", rom_we, 1'b0);
        check_eq("rst done", done, 1'b0);
        check_eq("rst z2base", z2ram_base, 8'h00);
        check_eq("rst z3cfg", z3ram_cfg, 1'b0);
        release_reset();
        check_eq("size patch count", we_cnt, 1);
        check_eq("size patch addr", we_addr, 8'h01);
        check_eq("size patch data", we_d, 4'h0);

        do_read("rd00", 9'h000, 16'hEFFF, 2);
        do_read("rd10", 9'h010, 16'hEFFF, 2);
        do_read("rd12", 9'h012, 16'hCFFF, 2);
        do_read("rd14", 9'h014, 16'h6FFF, 2);
        do_read("rd16", 9'h016, 16'h3FFF, 2);
        do_read("rd40", 9'h040, 16'h5FFF, 2);
        do_read("rd140", 9'h140, 16'h5FFF, 2);
        @(negedge clk);
        check_eq("rdata hold", rdata, 16'h5FFF);

        // Z2 base via nybble latch then commit
        do_write("wr4A", 9'h04A, 16'h2000, 2);
        check_eq("z2cfg after 4A", z2ram_cfg, 1'b0);
        check_eq("rdata hold wr", rdata, 16'h5FFF);
        do_write("wr48", 9'h048, 16'h2000, 2);
        check_eq("z2base", z2ram_base, 8'h22);
        check_eq("z2cfg", z2ram_cfg, 1'b1);
        do_read("rd00 z3", 9'h000, 16'hAFFF, 2);

        // Z3: mismatched offset is ignored, then base write
        do_write("wr48 z3", 9'h048, 16'h1234, 2);
        check_eq("z3cfg mismatch", z3ram_cfg, 1'b0);
        check_eq("z2base kept", z2ram_base, 8'h22);
        do_read("rd00 still z3", 9'h000, 16'hAFFF, 2);
        do_write("wr44 z3", 9'h044, 16'h4000, 2);
        check_eq("z3base", z3ram_base, 16'h4000);
        check_eq("z3cfg", z3ram_cfg, 1'b1);
        do_read("rd00 eth", 9'h000, 16'h8FFF, 2);

        // Ethernet shut up exhausts the chain
        do_write("wr4C eth", 9'h04C, 16'h0000, 2);
        check_eq("eth cfg shutup", eth_cfg, 1'b0);
        check_eq("done", done, 1'b1);
        do_read("rd done", 9'h000, 16'hFFFF, 1);
        do_write("wr done", 9'h044, 16'h5500, 1);
        check_eq("eth base done", eth_base, 16'h0000);

        // Only Ethernet present
        @(negedge clk);
        reset_n    = 1'b0;
        z2ram_size = 2'b00;
        en_z3ram   = 1'b0;
        en_eth     = 1'b1;
        @(negedge clk);
        check_eq("rst2 done", done, 1'b0);
        check_eq("rst2 z3base", z3ram_base, 16'h0000);
        release_reset();
        do_read("eth only rd00", 9'h000, 16'h8FFF, 2);
        do_write("eth only wr44", 9'h044, 16'h4100, 2);
        check_eq("eth only base", eth_base, 16'h4100);
        check_eq("eth only cfg", eth_cfg, 1'b1);
        check_eq("eth only done", done, 1'b1);

        // Reset asserted while a read sits in RD
        @(negedge clk);
        cfg_sel = 1'b1;
        req     = 1'b1;
        rw      = 1'b1;
        addr    = '0;
        @(negedge clk);
        req        = 1'b0;
        reset_n    = 1'b0;
        z2ram_size = 2'b11;
        en_z3ram   = 1'b1;
        #1;
        check_eq("abort ack", ack, 1'b0);
        check_eq("abort eth base", eth_base, 16'h0000);
        check_eq("abort eth cfg", eth_cfg, 1'b0);
        check_eq("abort done", done, 1'b0);
        @(negedge clk);
        check_eq("abort ack held", ack, 1'b0);
        check_eq("abort rdata", rdata, 16'hFFFF);
        cfg_sel = 1'b0;
        release_reset();
        check_eq("restart patch count", we_cnt, 1);
        do_read("restart rd00", 9'h000, 16'hEFFF, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
